mantissa_align: RTL
===================

MANTISSA_ALIGN -- requirements
Module: mantissa_align

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low; clock port clk, reset port rst_n.
REQ-002 SHALL provide ports, in order:
- clk  in  1  clock, rising edge
- rst_n  in  1  async active-low reset
- in_valid  in  1  input operand set valid
- in_ready  out  1  stage can accept input
- Sx, Sy  in  1 each  operand signs
- Ex, Ey  in  8 each  biased exponents
- Mx, My  in  23 each  stored fractions, no hidden bit
- d  in  8  exponent difference magnitude from exponent-difference stage
- sgn_d  in  1  1 = Y has larger exponent; 0 = X larger or equal
- zero_d  in  1  1 = exponents equal
- out_valid  out  1  aligned result valid
- out_ready  in  1  downstream accepts result
- E_l  out  8  larger exponent
- S_l, S_s  out  1 each  sign of larger / smaller operand
- M_l  out  24  larger significand with hidden bit
- M_s  out  27  smaller significand aligned: 24 bits, then guard, round, sticky

Function
REQ-003 SHALL insert hidden bit = OR of exponent bits; exponent 0 gives hidden bit 0 (denormal/zero).
REQ-004 SHALL select Y as larger operand when sgn_d=1, else X; when zero_d=1, SHALL select X and SHALL apply shift 0 regardless of d.
REQ-005 SHALL form M_s = ({small_significand, 3'b000} >> d), with bit 0 = OR of all bits shifted out plus the original bit 0.
REQ-006 For d >= 27, SHALL drive M_s bits 26..1 = 0 and bit 0 = OR of small significand.
REQ-007 SHALL be a 2-stage pipeline. Stage 1 registers operand selection, hidden bits and shift amount. Stage 2 registers shifter output.
REQ-008 Latency SHALL be 2 cycles from an accepted input (in_valid & in_ready at edge N) to out_valid at edge N+2, absent backpressure.
REQ-009 Throughput SHALL be 1 result/cycle while out_ready=1.
REQ-010 Stage 2 SHALL load when v2=0 or out_ready=1. Stage 1 SHALL load when v1=0 or stage 2 loads.
REQ-011 in_ready SHALL equal (v1=0) or (v2=0) or out_ready; this combinational out_ready-to-in_ready path is permitted.
REQ-012 While out_valid=1 and out_ready=0, all outputs SHALL hold stable.
REQ-013 A held stage SHALL not be overwritten, and no accepted operand SHALL be dropped or duplicated.
REQ-014 Simultaneous output transfer and input acceptance with both stages full SHALL advance the whole pipe in one cycle.
REQ-015 Data registers SHALL update only on stage load; contents are don't-care when the matching valid=0.

Reset
REQ-016 While rst_n=0, v1, v2 and out_valid SHALL be 0; data outputs E_l, S_l, S_s, M_l, M_s SHALL be 0.
REQ-017 rst_n asserted mid-operation SHALL discard all in-flight operands immediately; first acceptance after deassertion SHALL follow REQ-008 latency.
REQ-018 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-019 Shared package fpu_pkg SHALL hold EXP_W=8, FRAC_W=23, SIG_W=24, GRS_W=3 and the aligned-width constant 27; module SHALL use these constants, not literals.
REQ-020 Sticky-preserving right shifter SHALL be a sub-module align_shifter: 27-bit in, 8-bit shift, 27-bit out, combinational, instantiated between stages 1 and 2.

Verification
REQ-021 Ex=0x81, Mx=0, Ey=0x80, My=0, d=1, sgn_d=0, zero_d=0 -> after 2 cycles: E_l=0x81, M_l=0x800000, M_s=0x2000000.
REQ-022 Ex=0x10, Mx=0, Ey=0x30, My=0x000001, d=0x20, sgn_d=1 -> E_l=0x30, M_l=0x800001, M_s=0x0000001 (sticky only), S_l=Sy.
REQ-023 Ex=0x00, Mx=0x400000, Ey=0x01, My=0, d=1, sgn_d=1 -> M_l=0x800000; M_s=0x1000000 (hidden bit 0, shifted by 1).
REQ-024 Equal exponents Ex=Ey=0x7F, zero_d=1, d=0x05 -> no shift; M_s = {1, Mx, 000}.
REQ-025 Backpressure: stream 4 operands at in_valid=1 with out_ready=0 -> in_ready falls after 2 acceptances and outputs hold; then out_ready=1 -> 4 results in order, one per cycle.
REQ-026 rst_n pulsed low with 2 operands in flight -> out_valid=0 immediately; no stale result after release.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared floating-point field widths and pipeline record types
// for the add/sub datapath.
package fpu_pkg;
   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int SIG_W  = FRAC_W + 1;
   localparam int GRS_W  = 3;
   localparam int AL_W   = SIG_W + GRS_W;

   typedef struct packed {
      logic [EXP_W-1:0] e_l;
      logic             s_l;
      logic             s_s;
      logic [SIG_W-1:0] m_l;
      logic [SIG_W-1:0] m_s;
      logic [EXP_W-1:0] sh;
   } stage1_t;

   typedef struct packed {
      logic [EXP_W-1:0] e_l;
      logic             s_l;
      logic             s_s;
      logic [SIG_W-1:0] m_l;
      logic [AL_W-1:0]  m_s;
   } stage2_t;

   // Hidden bit is 1 for normals and 0 when the biased exponent is zero.
   function automatic logic [SIG_W-1:0] add_hidden(logic [EXP_W-1:0] e, logic [FRAC_W-1:0] m);
      return {|e, m};
   endfunction
endpackage

// File: rtl/align_shifter.sv
// align_shifter: combinational right shifter that folds every bit shifted
// out into the sticky bit (bit 0).
module align_shifter
   import fpu_pkg::*;
(
   input  logic [AL_W-1:0]  din,
   input  logic [EXP_W-1:0] sh,
   output logic [AL_W-1:0]  dout
);
   logic             far;
   logic [AL_W-1:0]  lost_mask;

   always_comb begin
      far       = sh >= EXP_W'(AL_W);
      lost_mask = ~({AL_W{1'b1}} << sh);
      dout      = far ? {{(AL_W-1){1'b0}}, |din}
                      : (din >> sh) | {{(AL_W-1){1'b0}}, |(din & lost_mask)};
   end
endmodule

// File: rtl/mantissa_align.sv
// mantissa_align: two-stage pipeline that picks the larger operand and
// aligns the smaller significand with guard/round/sticky bits.
module mantissa_align
   import fpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              Sx,
   input  logic              Sy,
   input  logic [EXP_W-1:0]  Ex,
   input  logic [EXP_W-1:0]  Ey,
   input  logic [FRAC_W-1:0] Mx,
   input  logic [FRAC_W-1:0] My,
   input  logic [EXP_W-1:0]  d,
   input  logic              sgn_d,
   input  logic              zero_d,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [EXP_W-1:0]  E_l,
   output logic              S_l,
   output logic              S_s,
   output logic [SIG_W-1:0]  M_l,
   output logic [AL_W-1:0]   M_s
);
   stage1_t          s1_d, s1_q, s1_n;
   stage2_t          s2_d, s2_q;
   logic             v1_d, v1_q, v2_d, v2_q;
   logic             ld1, ld2, sel_y;
   logic [AL_W-1:0]  shifted;

   align_shifter u_shift (
      .din  ({s1_q.m_s, {GRS_W{1'b0}}}),
      .sh   (s1_q.sh),
      .dout (shifted)
   );

   always_comb begin
      ld2        = !v2_q || out_ready;
      ld1        = !v1_q || ld2;
      sel_y      = sgn_d && !zero_d;
      s1_n.e_l   = sel_y ? Ey : Ex;
      s1_n.s_l   = sel_y ? Sy : Sx;
      s1_n.s_s   = sel_y ? Sx : Sy;
      s1_n.m_l   = sel_y ? add_hidden(Ey, My) : add_hidden(Ex, Mx);
      s1_n.m_s   = sel_y ? add_hidden(Ex, Mx) : add_hidden(Ey, My);
      // Equal exponents never shift, whatever the difference stage reports.
      s1_n.sh    = zero_d ? '0 : d;
      s1_d       = ld1 ? s1_n : s1_q;
      s2_d       = ld2 ? stage2_t'{s1_q.e_l, s1_q.s_l, s1_q.s_s, s1_q.m_l, shifted} : s2_q;
      v1_d       = ld1 ? in_valid : v1_q;
      v2_d       = ld2 ? v1_q : v2_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         v1_q <= v1_d;
         v2_q <= v2_d;
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign in_ready  = ld1;
   assign out_valid = v2_q;
   assign E_l       = s2_q.e_l;
   assign S_l       = s2_q.s_l;
   assign S_s       = s2_q.s_s;
   assign M_l       = s2_q.m_l;
   assign M_s       = s2_q.m_s;
endmodule
